// File: rtl/alpha_mean_pkg.sv
// Shared definitions for the alpha-trimmed mean controller: one-hot state
// encoding and the helpers that derive widths/counts from the parameters.
package alpha_mean_pkg;

    // One-hot controller states
    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_LAUNCH = 6'b000010,
        S_WAIT   = 6'b000100,
        S_ACCUM  = 6'b001000,
        S_DIV    = 6'b010000,
        S_OUT    = 6'b100000
    } state_t;

    // Number of samples kept after trimming alpha from each end
    function automatic int nkeep_f(input int dn, input int alpha);
        return dn - 2 * alpha;
    endfunction

    // Accumulator width able to hold the sum of a full window
    function automatic int sw_f(input int dn, input int dw);
        return dw + $clog2(dn);
    endfunction

    // Width of one original-index entry in the sorted list
    function automatic int sqw_f(input int dn);
        return $clog2(dn);
    endfunction

endpackage

// File: rtl/alpha_mean_ctrl_div.sv
// Restoring divider producing round(dividend / divisor), one quotient bit per
// cycle. The first bit is resolved in the start cycle, so a division takes
// exactly SW cycles from start to done (done and quotient are combinational
// in the final cycle).
module seq_div_const #(
    parameter int SW = 13,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = (SW > 1) ? $clog2(SW) : 1;

    logic          active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] step;
    logic [SW-1:0] rem;
    logic [SW-1:0] shreg;
    logic [SW-1:0] rounded;
    logic [SW-1:0] src;
    logic [SW-1:0] rem_src;
    logic [SW:0]   trial;
    logic [SW-1:0] rem_n;
    logic [SW-1:0] quo_n;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    // NOTE: every signal driven here gets a default first, so no branch can leave a latch.
    always_comb begin
        rounded  = dividend + (divisor >> 1);
        src      = start ? rounded : shreg;
        rem_src  = start ? '0 : rem;
        step     = start ? '0 : cnt;
        trial    = {rem_src, src[SW-1]};
        rem_n    = trial[SW-1:0];
        quo_n    = {src[SW-2:0], 1'b0};
        if (trial >= {1'b0, divisor}) begin
            rem_n = SW'(trial - {1'b0, divisor});
            quo_n = {src[SW-2:0], 1'b1};
        end
        done     = (start || active) && (step == CW'(SW - 1));
        quotient = quo_n[QW-1:0];
    end

    // Iteration registers: remainder, dividend/quotient shift register, step count
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            rem    <= '0;
            shreg  <= '0;
        end else if (start || active) begin
            rem   <= rem_n;
            shreg <= quo_n;
            if (done) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                active <= 1'b1;
                cnt    <= step + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alpha_mean_ctrl.sv
// Sequencing controller for the modified alpha-trimmed mean filter: accepts a
// window, launches the external rank-order sorter, sums the kept ranks and
// divides by the kept count with rounding. Falls back to the window centre if
// the sorter does not answer in time.
module alpha_mean_ctrl
    import alpha_mean_pkg::*;
#(
    parameter int DN      = 25,
    parameter int DW      = 8,
    parameter int ALPHA   = 5,
    parameter int TIMEOUT = 64,
    parameter int SQW     = sqw_f(DN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              win_valid,
    output logic              win_ready,
    input  logic [DW*DN-1:0]  win_data,
    output logic              sort_sig,
    output logic [DW*DN-1:0]  sort_data,
    input  logic              sort_finish,
    input  logic [SQW*DN-1:0] sequence_sorted,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_pixel,
    output logic              out_timeout,
    output logic              busy
);

    localparam int NKEEP  = nkeep_f(DN, ALPHA);
    localparam int SW     = sw_f(DN, DW);
    localparam int TW     = $clog2(TIMEOUT);
    localparam int CENTER = (DN - 1) / 2;

    localparam logic [SQW-1:0] R_FIRST = SQW'(ALPHA);
    localparam logic [SQW-1:0] R_LAST  = SQW'(DN - 1 - ALPHA);
    localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0]  DIVISOR = SW'(NKEEP);

    if (2 * ALPHA >= DN) begin : g_bad_alpha
        $error("alpha_mean_ctrl: 2*ALPHA must be smaller than DN");
    end
    if (DN % 2 == 0) begin : g_bad_dn
        $error("alpha_mean_ctrl: DN must be odd");
    end

    state_t            state;
    state_t            state_n;
    logic [SQW*DN-1:0] seq_q;
    logic [TW-1:0]     tcnt;
    logic [SQW-1:0]    r;
    logic [SW-1:0]     acc;
    logic              div_start;
    logic              div_done;
    logic [DW-1:0]     div_q;
    logic [DW-1:0]     pix [DN];
    logic [SQW-1:0]    seq [DN];
    logic [SQW-1:0]    rank_idx;

    // Views of the latched window and rank list as indexable arrays
    for (genvar k = 0; k < DN; k++) begin : g_unpack
        assign pix[k] = sort_data[k*DW +: DW];
        assign seq[k] = seq_q[k*SQW +: SQW];
    end

    assign rank_idx = seq[r];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        state_n   = state;
        win_ready = 1'b0;
        sort_sig  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                win_ready = !rst;
                if (win_valid) state_n = S_LAUNCH;
            end
            S_LAUNCH: begin
                sort_sig = 1'b1;
                state_n  = S_WAIT;
            end
            S_WAIT: begin
                if (sort_finish)         state_n = S_ACCUM;
                else if (tcnt == T_LAST) state_n = S_OUT;
            end
            S_ACCUM: begin
                if (r == R_LAST) state_n = S_DIV;
            end
            S_DIV: begin
                if (div_done) state_n = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: window latch, timeout count, rank walk/accumulate, result capture
    always_ff @(posedge clk) begin
        // NOTE: the window and rank-list registers are plain flops, so they are reset along with the rest; sort_data reads 0 after reset.
        if (rst) begin
            sort_data   <= '0;
            seq_q       <= '0;
            tcnt        <= '0;
            r           <= '0;
            acc         <= '0;
            div_start   <= 1'b0;
            out_pixel   <= '0;
            out_timeout <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_valid) sort_data <= win_data;
                end
                S_LAUNCH: begin
                    tcnt <= '0;
                end
                S_WAIT: begin
                    if (sort_finish) begin
                        seq_q <= sequence_sorted;
                        r     <= R_FIRST;
                        acc   <= '0;
                    end else if (tcnt == T_LAST) begin
                        out_pixel   <= pix[CENTER];
                        out_timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_ACCUM: begin
                    acc <= acc + SW'(pix[rank_idx]);
                    r   <= r + 1'b1;
                    if (r == R_LAST) div_start <= 1'b1;
                end
                S_DIV: begin
                    if (div_done) begin
                        out_pixel   <= div_q;
                        out_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    seq_div_const #(
        .SW (SW),
        .QW (DW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (acc),
        .divisor  (DIVISOR),
        .done     (div_done),
        .quotient (div_q)
    );

endmodule

// File: tb/tb_alpha_mean_ctrl.sv
// Scoreboard bench for alpha_mean_ctrl: a sorter model answers sort_sig after
// a chosen delay, the driver pushes expected results computed from the
// trimmed-mean definition, and a monitor pops and compares each output.
module tb_alpha_mean_ctrl;

    localparam int DN      = 25;
    localparam int DW      = 8;
    localparam int ALPHA   = 5;
    localparam int TIMEOUT = 64;
    localparam int SQW     = 5;
    localparam int NKEEP   = DN - 2 * ALPHA;
    localparam int SW      = DW + $clog2(DN);
    localparam int CENTER  = (DN - 1) / 2;
    localparam int WW      = DW * DN;

    typedef struct {
        int pixel;
        int to;
        int lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              win_valid = 1'b0;
    logic              win_ready;
    logic [WW-1:0]     win_data = '0;
    logic              sort_sig;
    logic [WW-1:0]     sort_data;
    logic              sort_finish = 1'b0;
    logic [SQW*DN-1:0] sequence_sorted = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_pixel;
    logic              out_timeout;
    logic              busy;

    logic [WW-1:0] cur_window = '0;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_hs_cyc = 0;
    int done_count = 0;
    int sorter_delay = 1;
    exp_t exp_q[$];

    alpha_mean_ctrl #(
        .DN      (DN),
        .DW      (DW),
        .ALPHA   (ALPHA),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .win_valid       (win_valid),
        .win_ready       (win_ready),
        .win_data        (win_data),
        .sort_sig        (sort_sig),
        .sort_data       (sort_data),
        .sort_finish     (sort_finish),
        .sequence_sorted (sequence_sorted),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pixel       (out_pixel),
        .out_timeout     (out_timeout),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Trimmed mean straight from the definition: sort, keep the middle, round-divide
    function automatic int ref_mean(input logic [WW-1:0] w);
        int v[$];
        int s = 0;
        for (int k = 0; k < DN; k++) v.push_back(int'(w[k*DW +: DW]));
        v.sort();
        for (int i = ALPHA; i <= DN - 1 - ALPHA; i++) s += v[i];
        return (s + NKEEP / 2) / NKEEP;
    endfunction

    // Sorter model output: original indices listed in ascending value order
    function automatic logic [SQW*DN-1:0] sorter_order(input logic [WW-1:0] w);
        int idx[DN];
        int t;
        logic [SQW*DN-1:0] res;
        for (int k = 0; k < DN; k++) idx[k] = k;
        for (int i = 1; i < DN; i++) begin
            for (int j = i; j > 0; j--) begin
                if (w[idx[j-1]*DW +: DW] > w[idx[j]*DW +: DW]) begin
                    t = idx[j-1]; idx[j-1] = idx[j]; idx[j] = t;
                end
            end
        end
        res = '0;
        for (int r = 0; r < DN; r++) res[r*SQW +: SQW] = SQW'(idx[r]);
        return res;
    endfunction

    function automatic logic [SQW*DN-1:0] junk_seq();
        logic [SQW*DN-1:0] res;
        for (int r = 0; r < DN; r++) res[r*SQW +: SQW] = SQW'($urandom_range(0, 31));
        return res;
    endfunction

    function automatic logic [WW-1:0] rand_window(input int mode);
        logic [WW-1:0] w;
        int base;
        base = $urandom_range(0, 255);
        for (int k = 0; k < DN; k++) begin
            case (mode)
                0:       w[k*DW +: DW] = DW'($urandom_range(0, 255));
                1:       w[k*DW +: DW] = DW'($urandom_range(40, 47));
                default: w[k*DW +: DW] = ($urandom_range(0, 4) == 0) ? DW'($urandom_range(0, 255)) : DW'(base);
            endcase
        end
        return w;
    endfunction

    // Sorter model: answers sort_sig with a finish pulse after sorter_delay cycles
    initial begin
        int d;
        logic [SQW*DN-1:0] order;
        sequence_sorted = junk_seq();
        forever begin
            @(negedge clk);
            if (sort_sig) begin
                d = sorter_delay;
                check("sort_data_latched", sort_data, cur_window);
                if (d > 0) begin
                    order = sorter_order(cur_window);
                    repeat (d) @(posedge clk);
                    #1;
                    sort_finish     = 1'b1;
                    sequence_sorted = order;
                    @(posedge clk);
                    #1;
                    sort_finish     = 1'b0;
                    sequence_sorted = junk_seq();
                end
            end
        end
    end

    // Monitor: pops one expectation per output and checks it is held under backpressure
    initial begin
        exp_t e;
        logic prev_valid = 1'b0;
        logic prev_sig = 1'b0;
        int held_pix = 0;
        int held_to = 0;
        forever begin
            @(negedge clk);
            if (prev_sig) check("sort_sig_one_cycle", sort_sig, 0);
            prev_sig = sort_sig;
            if (out_valid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_pixel", out_pixel, e.pixel);
                        check("out_timeout", out_timeout, e.to);
                        check("latency", cyc - accept_cyc, e.lat);
                    end
                    held_pix = int'(out_pixel);
                    held_to  = int'(out_timeout);
                end else begin
                    check("hold_pixel", out_pixel, held_pix);
                    check("hold_timeout", out_timeout, held_to);
                end
                if (out_ready) begin
                    last_hs_cyc = cyc;
                    done_count++;
                end
            end
            prev_valid = out_valid && !out_ready;
        end
    end

    // Offer a window (called just after a rising edge); d<0 means the sorter never answers
    task automatic send_window(input logic [WW-1:0] w, input int d, input bit expect_out);
        exp_t e;
        bit accepted = 1'b0;
        if (d < 0) begin
            e.pixel = int'(w[CENTER*DW +: DW]);
            e.to    = 1;
            e.lat   = 2 + TIMEOUT;
        end else begin
            e.pixel = ref_mean(w);
            e.to    = 0;
            e.lat   = 2 + d + NKEEP + SW;
        end
        if (expect_out) exp_q.push_back(e);
        cur_window   = w;
        sorter_delay = d;
        win_data     = w;
        win_valid    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (win_ready) begin
                accepted   = 1'b1;
                accept_cyc = cyc;
                break;
            end
        end
        if (!accepted) check("window_accept", 0, 1);
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        win_data  = rand_window(0);
    endtask

    task automatic wait_outputs(input int target, input int budget, input bit rnd);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            n++;
        end
        out_ready = 1'b1;
        if (done_count < target) check("output_wait", done_count, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d outputs", done_count);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [WW-1:0] w;
        int target = 0;
        int n;
        int d;

        // Reset values
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_win_ready", win_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sort_sig", sort_sig, 0);
        check("rst_sort_data", sort_data, 0);
        check("rst_out_pixel", out_pixel, 0);
        check("rst_out_timeout", out_timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_win_ready", win_ready, 1);
        check("idle_busy", busy, 0);
        @(posedge clk);
        #1;

        // Ramp 0..24, sorter answers after 3 cycles -> 12
        for (int k = 0; k < DN; k++) w[k*DW +: DW] = DW'(k);
        send_window(w, 3, 1);
        target++;
        wait_outputs(target, 300, 0);

        // Flat 255 -> 255
        w = '1;
        send_window(w, 2, 1);
        target++;
        wait_outputs(target, 300, 0);

        // 20 x 100 with five zeros trimmed away -> 100
        for (int k = 0; k < DN; k++) w[k*DW +: DW] = (k % 6 == 0) ? DW'(0) : DW'(100);
        send_window(w, 5, 1);
        target++;
        wait_outputs(target, 300, 0);

        // Sorter never answers -> centre pixel 0x5A with timeout flag
        w = rand_window(0);
        w[CENTER*DW +: DW] = 8'h5A;
        send_window(w, -1, 1);
        target++;
        wait_outputs(target, 400, 0);

        // Backpressure: hold out_ready low for 10 cycles of out_valid
        out_ready = 1'b0;
        send_window(rand_window(0), 2, 1);
        target++;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_win_ready", win_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_window(rand_window(2), 4, 1);
        target++;
        check("accept_after_release", accept_cyc, last_hs_cyc + 1);
        wait_outputs(target, 300, 0);

        // Reset during WAIT; the sorter's late finish must not produce output
        send_window(rand_window(0), 12, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sort_sig", sort_sig, 0);
        check("midrst_busy", busy, 0);
        check("midrst_win_ready", win_ready, 1);
        check("midrst_sort_data", sort_data, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("midrst_stays_idle", busy, 0);
        end
        check("midrst_no_output", done_count, target);
        @(posedge clk);
        #1;

        // Randomized windows, sorter delays and output backpressure
        for (int i = 0; i < 20; i++) begin
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 8));
            send_window(rand_window(int'($urandom_range(0, 2))), d, 1);
            target++;
            wait_outputs(target, 500, 1);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("output_count", done_count, target);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
